// File: rtl/stopwatch_count_scan.sv
// Stopwatch core: start/stop/clear FSM, BCD MM:SS counter and 4-digit 7-segment scan driver.
// Optional lap/freeze display hold is enabled by defining LAP_HOLD_EN.
module stopwatch_count_scan #(
  parameter int MIN_MAX = 99,
  parameter bit SEG_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sec_tick,
  input  logic        scan_tick,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [15:0] bcd,
  output logic        running,
  output logic        wrap
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  localparam logic [7:0] MM_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  state_t      r_state;
  logic        r_start_q, r_clear_q;
  logic [15:0] r_bcd;
  logic        r_running, r_wrap;
  logic [1:0]  r_idx;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_start_e, w_clear_e, w_at_max;
  logic [15:0] w_bcd_inc, w_disp;
  logic [3:0]  w_digit;

  assign w_start_e = btn_start & ~r_start_q;
  assign w_clear_e = btn_clear & ~r_clear_q;
  assign w_at_max  = (r_bcd[15:8] == MM_BCD) && (r_bcd[7:0] == 8'h59);

  // Ripple BCD increment; the wrap at MIN_MAX:59 is handled separately.
  always_comb begin
    w_bcd_inc = r_bcd;
    if (r_bcd[3:0] != 4'd9) w_bcd_inc[3:0] = r_bcd[3:0] + 4'd1;
    else begin
      w_bcd_inc[3:0] = 4'd0;
      if (r_bcd[7:4] != 4'd5) w_bcd_inc[7:4] = r_bcd[7:4] + 4'd1;
      else begin
        w_bcd_inc[7:4] = 4'd0;
        if (r_bcd[11:8] != 4'd9) w_bcd_inc[11:8] = r_bcd[11:8] + 4'd1;
        else begin
          w_bcd_inc[11:8]  = 4'd0;
          w_bcd_inc[15:12] = r_bcd[15:12] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_clear_q <= 1'b0;
      r_bcd     <= 16'h0000;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_start_q <= btn_start;
      r_clear_q <= btn_clear;
      r_wrap    <= 1'b0;
      if (r_state == S_RUN && sec_tick) begin
        if (w_at_max) begin
          r_bcd  <= 16'h0000;
          r_wrap <= 1'b1;
        end else begin
          r_bcd <= w_bcd_inc;
        end
      end
      // Clear outranks start outside RUN; clear is ignored while running.
      case (r_state)
        S_IDLE: begin
          if (w_clear_e) r_bcd <= 16'h0000;
          else if (w_start_e) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_start_e) begin
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (w_clear_e) begin
            r_state <= S_IDLE;
            r_bcd   <= 16'h0000;
          end else if (w_start_e) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

`ifdef LAP_HOLD_EN
  logic        r_lap_q, r_frozen;
  logic [15:0] r_lap;
  logic        w_lap_e;

  assign w_lap_e = btn_lap & ~r_lap_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lap_q  <= 1'b0;
      r_frozen <= 1'b0;
      r_lap    <= 16'h0000;
    end else begin
      r_lap_q <= btn_lap;
      if (r_state == S_RUN && w_lap_e) begin
        r_frozen <= ~r_frozen;
        if (!r_frozen) r_lap <= r_bcd;
      end
      // Leaving PAUSE via clear is the only way into IDLE.
      if (r_state == S_PAUSE && w_clear_e) r_frozen <= 1'b0;
    end
  end

  assign w_disp = r_frozen ? r_lap : r_bcd;
`else
  logic w_unused_lap;
  assign w_unused_lap = btn_lap;
  assign w_disp       = r_bcd;
`endif

  function automatic logic [6:0] f_dec(input logic [3:0] d);
    case (d)
      4'd0: f_dec = 7'b0111111;
      4'd1: f_dec = 7'b0000110;
      4'd2: f_dec = 7'b1011011;
      4'd3: f_dec = 7'b1001111;
      4'd4: f_dec = 7'b1100110;
      4'd5: f_dec = 7'b1101101;
      4'd6: f_dec = 7'b1111101;
      4'd7: f_dec = 7'b0000111;
      4'd8: f_dec = 7'b1111111;
      4'd9: f_dec = 7'b1101111;
      default: f_dec = 7'b0000000;
    endcase
  endfunction

  assign w_digit = w_disp[{r_idx, 2'b00} +: 4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= 2'd0;
      r_an  <= 4'b1110;
      r_seg <= SEG_POL ? f_dec(4'd0) : ~f_dec(4'd0);
      r_dp  <= ~SEG_POL;
    end else begin
      if (scan_tick) r_idx <= r_idx + 2'd1;
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= SEG_POL ? f_dec(w_digit) : ~f_dec(w_digit);
      r_dp  <= (r_idx == 2'd2) ? SEG_POL : ~SEG_POL;
    end
  end

  assign an      = r_an;
  assign seg     = r_seg;
  assign dp      = r_dp;
  assign bcd     = r_bcd;
  assign running = r_running;
  assign wrap    = r_wrap;
endmodule

// File: tb/tb_stopwatch_count_scan.sv
// Scoreboard bench for stopwatch_count_scan: a seconds-based model pushes expected
// {wrap,running,bcd} per stimulus cycle; display scans are checked against segment tables.
module tb_stopwatch_count_scan;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sec_tick = 1'b0, scan_tick = 1'b0;
  logic        btn_start = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] bcd;
  logic        running, wrap;

  int n_chk = 0, n_pass = 0;
  int m_cnt = 0, m_st = 0, m_idx = 0;
  logic [17:0] sb_q[$];

  stopwatch_count_scan dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .scan_tick(scan_tick),
    .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .an(an), .seg(seg), .dp(dp), .bcd(bcd), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    int m, s;
    m = n / 60;
    s = n % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Active-low Basys3 patterns {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] t[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  // One stimulus cycle: drive, update model, push expectation, then compare the DUT result.
  task automatic cyc(input string tag, input bit st, input bit cl, input bit lp, input bit sc, input bit sn);
    bit w;
    logic [17:0] e;
    @(negedge clk);
    btn_start = st; btn_clear = cl; btn_lap = lp; sec_tick = sc; scan_tick = sn;
    w = 1'b0;
    if (m_st == 1 && sc) begin
      m_cnt = (m_cnt + 1) % 6000;
      w = (m_cnt == 0);
    end
    case (m_st)
      0: if (cl) m_cnt = 0; else if (st) m_st = 1;
      1: if (st) m_st = 2;
      default: if (cl) begin m_st = 0; m_cnt = 0; end else if (st) m_st = 1;
    endcase
    if (sn) m_idx = (m_idx + 1) % 4;
    sb_q.push_back({w, (m_st == 1), to_bcd(m_cnt)});
    @(negedge clk);
    btn_start = 0; btn_clear = 0; btn_lap = 0; sec_tick = 0; scan_tick = 0;
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else begin
      e = sb_q.pop_front();
      chk(tag, {14'd0, wrap, running, bcd}, {14'd0, e});
    end
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 1, 0);
  endtask

  // Walk all four digits and compare anode, segments and dp against the shown value.
  task automatic scan_chk(input string tag, input logic [15:0] shown);
    logic [15:0] v;
    for (int k = 0; k < 4; k++) begin
      cyc({tag, "_sb"}, 0, 0, 0, 0, 1);
      @(negedge clk);
      v = shown >> (4 * m_idx);
      chk({tag, "_an"}, {28'd0, an}, {28'd0, ~(4'b0001 << m_idx)});
      chk({tag, "_seg"}, {25'd0, seg}, {25'd0, seg_of(v[3:0])});
      chk({tag, "_dp"}, {31'd0, dp}, {31'd0, (m_idx != 2)});
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_async_bcd"}, {16'd0, bcd}, 32'h0);
    chk({tag, "_async_flags"}, {30'd0, running, wrap}, 32'd0);
    chk({tag, "_async_an"}, {28'd0, an}, 32'he);
    @(negedge clk);
    chk({tag, "_hold_seg"}, {25'd0, seg}, 32'h40);
    chk({tag, "_hold_dp"}, {31'd0, dp}, 32'd1);
    reset = 1'b0;
    m_cnt = 0; m_st = 0; m_idx = 0;
    sb_q.delete();
    @(negedge clk);
    chk({tag, "_rel"}, {9'd0, an, seg, running, bcd}, {9'd0, 4'b1110, 7'b1000000, 1'b0, 16'h0});
  endtask

  initial begin
    // 1: reset values
    do_reset("reset");

    // 2: count 75 s, pause keeps count, clear returns to IDLE
    cyc("start", 1, 0, 0, 0, 0);
    ticks("run75", 75);
    chk("bcd_0115", {16'd0, bcd}, 32'h0115);
    cyc("clr_in_run", 0, 1, 0, 0, 0);
    cyc("stop", 1, 0, 0, 0, 0);
    ticks("paused", 3);

    // 4: scan over 01:15 while paused
    scan_chk("scan", 16'h0115);

    // 5: simultaneous start+clear in RUN then PAUSE
    cyc("resume", 1, 0, 0, 0, 0);
    cyc("stclr_run", 1, 1, 0, 1, 0);
    chk("kept", {16'd0, bcd}, 32'h0116);
    cyc("stclr_pause", 1, 1, 0, 0, 0);
    cyc("idle_clr", 0, 1, 0, 1, 0);

    // 3: sec_tick with the start edge is not counted; preload to 99:58, wrap
    cyc("start_tick", 1, 0, 0, 1, 0);
    ticks("pre", 5998);
    chk("bcd_9958", {16'd0, bcd}, 32'h9958);
    ticks("to_9959", 1);
    ticks("wrap", 1);
    chk("wrap_pulse", {29'd0, wrap, running, 1'b0}, 32'b110);
    cyc("wrap_end", 0, 0, 0, 0, 0);
    ticks("post_wrap", 2);
    cyc("both_ticks", 0, 0, 0, 1, 1);

    // reset mid-run
    do_reset("mid_reset");

`ifdef LAP_HOLD_EN
    // 6: lap freeze at 00:10
    cyc("lap_start", 1, 0, 0, 0, 0);
    ticks("lap_pre", 10);
    cyc("lap_set", 0, 0, 1, 0, 0);
    ticks("lap_run", 5);
    scan_chk("lap_frozen", 16'h0010);
    cyc("lap_rel", 0, 0, 1, 0, 0);
    scan_chk("lap_live", 16'h0015);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
